// File: rtl/tl_ul_inflight_monitor_if.sv
// tl_ul_inflight_monitor_if: TL-UL A/D channel signals observed by the in-flight monitor
interface tl_ul_inflight_monitor_if #(
    parameter int SOURCE_BITS = 3,
    parameter int ADDR_BITS   = 31
);
    logic                   a_valid;
    logic                   a_ready;
    logic [2:0]             a_opcode;
    logic [2:0]             a_size;
    logic [SOURCE_BITS-1:0] a_source;
    logic [ADDR_BITS-1:0]   a_address;
    logic                   d_valid;
    logic                   d_ready;
    logic [2:0]             d_opcode;
    logic [2:0]             d_size;
    logic [SOURCE_BITS-1:0] d_source;

    modport master (
        output a_valid, a_ready, a_opcode, a_size, a_source, a_address,
        output d_valid, d_ready, d_opcode, d_size, d_source
    );

    modport slave (
        input a_valid, a_ready, a_opcode, a_size, a_source, a_address,
        input d_valid, d_ready, d_opcode, d_size, d_source
    );
endinterface

// File: rtl/tl_ul_inflight_monitor.sv
// tl_ul_inflight_monitor: tracks per-source TL-UL outstanding requests and flags protocol violations
module tl_ul_inflight_monitor #(
    parameter int SOURCE_BITS = 3,
    parameter int ADDR_BITS   = 31,
    parameter int BEAT_LOG2   = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic                   clock,
    input  logic                   reset_n,
    tl_ul_inflight_monitor_if.slave tl,
    output logic                   err_pulse,
    output logic [3:0]             err_code,
    output logic                   err_sticky,
    output logic [7:0]             err_count,
    output logic [SOURCE_BITS:0]   inflight_count
);
    localparam int N  = 1 << SOURCE_BITS;
    localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;

    logic [N-1:0]           inflight_q, inflight_n, get_q;
    logic [2:0]             size_q [N];
    logic                   a_fire, d_fire, d_hit;
    logic                   a_hold_q, d_hold_q;
    logic [2:0]             a_op_q, a_sz_q, d_op_q, d_sz_q;
    logic [SOURCE_BITS-1:0] a_src_q, d_src_q;
    logic [ADDR_BITS-1:0]   a_addr_q;
    logic [TW-1:0]          tmo_q, tmo_inc;
    logic                   tmo_run, tmo_hit;
    logic [10:1]            err;
    logic [3:0]             code_n;
    logic [SOURCE_BITS:0]   pop_n;

    assign a_fire  = tl.a_valid & tl.a_ready;
    assign d_fire  = tl.d_valid & tl.d_ready;
    assign d_hit   = d_fire & inflight_q[tl.d_source];
    assign tmo_run = (inflight_count != '0) && !d_fire;
    assign tmo_inc = tmo_q + 1'b1;
    assign tmo_hit = (TIMEOUT != 0) && tmo_run && (tmo_inc == TW'(TIMEOUT));

    assign err[1]  = a_fire && !(tl.a_opcode inside {3'd0, 3'd1, 3'd4});
    assign err[2]  = a_fire && (tl.a_size > 3'(BEAT_LOG2));
    assign err[3]  = a_fire && ((tl.a_address & ~({ADDR_BITS{1'b1}} << tl.a_size)) != '0);
    assign err[4]  = a_fire && inflight_q[tl.a_source] && !(d_fire && tl.d_source == tl.a_source);
    assign err[5]  = d_fire && !inflight_q[tl.d_source];
    assign err[6]  = d_hit && (tl.d_opcode != (get_q[tl.d_source] ? 3'd1 : 3'd0));
    assign err[7]  = d_hit && (tl.d_size != size_q[tl.d_source]);
    assign err[8]  = a_hold_q && (!tl.a_valid ||
                     {tl.a_opcode, tl.a_size, tl.a_source, tl.a_address} != {a_op_q, a_sz_q, a_src_q, a_addr_q});
    assign err[9]  = d_hold_q && (!tl.d_valid ||
                     {tl.d_opcode, tl.d_size, tl.d_source} != {d_op_q, d_sz_q, d_src_q});
    assign err[10] = tmo_hit;

    always_comb begin
        code_n = '0;
        for (int i = 10; i >= 1; i--) code_n = err[i] ? 4'(i) : code_n;
    end

    // a retiring D frees its source before a same-cycle A re-allocates it
    always_comb begin
        inflight_n = inflight_q;
        if (d_hit) inflight_n[tl.d_source] = 1'b0;
        if (a_fire) inflight_n[tl.a_source] = 1'b1;
        pop_n = '0;
        for (int i = 0; i < N; i++) pop_n = pop_n + {{SOURCE_BITS{1'b0}}, inflight_n[i]};
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q     <= '0;
            get_q          <= '0;
            size_q         <= '{default: '0};
            a_hold_q       <= 1'b0;
            d_hold_q       <= 1'b0;
            a_op_q         <= '0;
            a_sz_q         <= '0;
            a_src_q        <= '0;
            a_addr_q       <= '0;
            d_op_q         <= '0;
            d_sz_q         <= '0;
            d_src_q        <= '0;
            tmo_q          <= '0;
            err_pulse      <= 1'b0;
            err_code       <= '0;
            err_sticky     <= 1'b0;
            err_count      <= '0;
            inflight_count <= '0;
        end else begin
            inflight_q <= inflight_n;
            if (a_fire) begin
                get_q[tl.a_source]  <= tl.a_opcode == 3'd4;
                size_q[tl.a_source] <= tl.a_size;
            end
            a_hold_q       <= tl.a_valid & ~tl.a_ready;
            d_hold_q       <= tl.d_valid & ~tl.d_ready;
            a_op_q         <= tl.a_opcode;
            a_sz_q         <= tl.a_size;
            a_src_q        <= tl.a_source;
            a_addr_q       <= tl.a_address;
            d_op_q         <= tl.d_opcode;
            d_sz_q         <= tl.d_size;
            d_src_q        <= tl.d_source;
            tmo_q          <= (tmo_run && !tmo_hit) ? tmo_inc : '0;
            err_pulse      <= |err;
            inflight_count <= pop_n;
            if (|err && !err_sticky) begin
                err_sticky <= 1'b1;
                err_code   <= code_n;
            end
            if (|err && err_count != 8'hff) err_count <= err_count + 8'd1;
        end
    end
endmodule

// File: doc/tl_ul_inflight_monitor.md
TL_UL_INFLIGHT_MONITOR -- requirements
Module: tl_ul_inflight_monitor

Interface
REQ-001 Parameters SHALL be:
- SOURCE_BITS, 3, A/D source ID width; tracks 2^SOURCE_BITS IDs.
- ADDR_BITS, 31, A address width.
- BEAT_LOG2, 2, log2 of beat bytes; max legal size.
- TIMEOUT, 1024, idle cycles before hang error; 0 disables.
REQ-002 Ports SHALL be:
- clock  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- a_valid / a_ready  in  1  A-channel handshake.
- a_opcode  in  3  A opcode.
- a_size  in  3  log2 bytes.
- a_source  in  SOURCE_BITS  A source ID.
- a_address  in  ADDR_BITS  A address.
- d_valid / d_ready  in  1  D-channel handshake.
- d_opcode  in  3  D opcode.
- d_size  in  3  D size.
- d_source  in  SOURCE_BITS  D source ID.
- err_pulse  out  1  high one cycle per cycle with any violation.
- err_code  out  4  first violation code, sticky.
- err_sticky  out  1  set on first violation.
- err_count  out  8  saturating violation-cycle count.
- inflight_count  out  SOURCE_BITS+1  outstanding requests.
REQ-003 Clocking SHALL be one clock; reset SHALL be asynchronous and active-low.

Function
REQ-004 A fire = a_valid&a_ready; D fire = d_valid&d_ready.
REQ-005 Per-source state SHALL be: in-flight bit, recorded opcode class (get/put), recorded size.
REQ-006 On A fire, the block SHALL set the in-flight bit and record class and size for a_source.
REQ-007 On D fire, the block SHALL clear the in-flight bit for d_source.
REQ-008 D fire and A fire on the same source in one cycle SHALL be legal if the source was in flight: D retires first, A re-allocates.
REQ-009 Error codes (lower number = higher priority in one cycle) SHALL be:
- 1 A_OPCODE: a_opcode not in {0 PutFull, 1 PutPartial, 4 Get}.
- 2 A_SIZE: a_size > BEAT_LOG2.
- 3 A_ALIGN: a_address low a_size bits nonzero.
- 4 A_REUSE: A fire on a source in flight and not retired same cycle.
- 5 D_UNKNOWN: D fire on a source not in flight; A fire same cycle does not count.
- 6 D_OPCODE: Get expects d_opcode 1, Put expects 0.
- 7 D_SIZE: d_size != recorded size.
- 8 A_STABLE: A valid&!ready last cycle, and this cycle a_valid dropped or any A field changed.
- 9 D_STABLE: the same check on D.
- 10 TIMEOUT: the timeout counter reaches TIMEOUT.
REQ-010 Checks 1-3 SHALL evaluate on A fire only; 5-7 on D fire only.
REQ-011 An erroneous A fire SHALL still allocate; an erroneous D fire (5) SHALL NOT alter state.
REQ-012 err_pulse SHALL assert in the cycle after the violating edge (one registered stage).
REQ-013 err_code SHALL capture the highest-priority code of the first violating cycle and hold it until reset.
REQ-014 err_count SHALL increment once per violating cycle and saturate at 255.
REQ-015 inflight_count SHALL equal the popcount of in-flight bits, registered, updated the cycle after a fire.
REQ-016 The timeout counter SHALL increment each cycle inflight_count != 0 with no D fire.
REQ-017 The timeout counter SHALL clear on D fire or when inflight_count == 0.
REQ-018 On reaching TIMEOUT, the block SHALL flag code 10 once, then clear the counter.
REQ-019 No output SHALL depend combinationally on inputs.

Reset
REQ-020 With reset_n low, outputs SHALL be 0: err_pulse, err_code, err_sticky, err_count, inflight_count.
REQ-021 With reset_n low, all in-flight bits, stability history and the timeout counter SHALL clear.
REQ-022 Reset asserted mid-transaction SHALL discard all outstanding state; post-reset D for an old source SHALL flag code 5.

Verification
REQ-023 Get src 2, size 2, addr 0x100; D opcode 1 size 2 src 2 -> no error; inflight_count 1 then 0.
REQ-024 Get src 1 addr 0x102 size 2 -> err_pulse one cycle, err_code 3, err_count 1.
REQ-025 Two A fires src 0 with no D -> second flags code 4; D src 0 plus A src 0 same cycle -> no error.
REQ-026 PutFull src 3 answered with d_opcode 1 -> code 6; later D src 5 never issued -> err_code stays 6, err_count 2.
REQ-027 a_valid high, a_ready low, a_address changes next cycle -> code 8.
REQ-028 TIMEOUT=16: one Get, no D for 16 cycles -> single code-10 pulse; reset_n low mid-wait -> all outputs 0.
